// File: rtl/exec_sequencer_pkg.sv
// Shared constants and state type for the execution sequencer.
// Default command bytes, HALT word and drain depth live here.
package exec_sequencer_pkg;

  localparam int          DEF_DATA_W    = 8;
  localparam int          DEF_IMEM_AW   = 6;
  localparam logic [7:0]  DEF_CMD_LOAD  = 8'h4C;
  localparam logic [7:0]  DEF_CMD_RUN   = 8'h52;
  localparam logic [7:0]  DEF_CMD_STEP  = 8'h53;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;
  localparam int          DEF_DRAIN_CYC = 3;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_LOAD    = 3'd1,
    SEQ_RUN     = 3'd2,
    SEQ_DRAIN   = 3'd3,
    SEQ_SEND    = 3'd4,
    SEQ_WAIT_TX = 3'd5
  } seq_state_e;

endpackage

// File: rtl/exec_sequencer_word_assembler.sv
// Collects four little-endian bytes into a 32-bit word.
// Ports: clear_i restarts the byte count; word_valid_o pulses on the 4th byte.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] lo_q, lo_d;
  logic [1:0]  cnt_q, cnt_d;

  // Bytes enter at the top and shift down, so after three
  // bytes lo_q holds {b2, b1, b0} and the 4th byte completes it.
  always_comb begin
    lo_d         = lo_q;
    cnt_d        = cnt_q;
    word_o       = {byte_i, lo_q};
    word_valid_o = 1'b0;
    if (clear_i) begin
      lo_d  = '0;
      cnt_d = '0;
    end else if (byte_valid_i) begin
      lo_d         = {byte_i, lo_q[23:8]};
      cnt_d        = cnt_q + 2'd1;
      word_valid_o = (cnt_q == 2'd3);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lo_q  <= '0;
      cnt_q <= '0;
    end else begin
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// Loads IMEM over UART, runs/steps the 4-stage pipeline, sends WB byte.
// Ports: rx_*/tx_* UART side; instr_in/wb_data/dp_reset/pc_write/imem_* datapath side.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int          DATA_W    = DEF_DATA_W,
  parameter int          IMEM_AW   = DEF_IMEM_AW,
  parameter logic [7:0]  CMD_LOAD  = DEF_CMD_LOAD,
  parameter logic [7:0]  CMD_RUN   = DEF_CMD_RUN,
  parameter logic [7:0]  CMD_STEP  = DEF_CMD_STEP,
  parameter logic [31:0] HALT_WORD = DEF_HALT_WORD,
  parameter int          DRAIN_CYC = DEF_DRAIN_CYC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               tx_done,
  input  logic [31:0]        instr_in,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               dp_reset,
  output logic               pc_write,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  output logic               tx_start,
  output logic [7:0]         tx_byte,
  output logic               busy,
  output logic               load_err
);

  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);
  localparam logic [IMEM_AW-1:0] ADDR_MAX = '1;

  seq_state_e         state_q, state_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [DCW-1:0]     drain_q, drain_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               load_err_q, load_err_d;
  logic               run_first_q, run_first_d;

  logic               asm_clear;
  logic               asm_valid;
  logic [31:0]        asm_word;

  word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (asm_clear),
    .byte_valid_i (rx_valid && (state_q == SEQ_LOAD)),
    .byte_i       (rx_data),
    .word_o       (asm_word),
    .word_valid_o (asm_valid)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    drain_d     = drain_q;
    tx_byte_d   = tx_byte_q;
    load_err_d  = load_err_q;
    run_first_d = 1'b0;
    asm_clear   = 1'b0;
    dp_reset    = 1'b0;
    pc_write    = 1'b0;
    imem_we     = 1'b0;
    tx_start    = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_LOAD) begin
            state_d    = SEQ_LOAD;
            addr_d     = '0;
            load_err_d = 1'b0;
            asm_clear  = 1'b1;
          end else if (rx_data == CMD_RUN) begin
            dp_reset    = 1'b1;
            run_first_d = 1'b1;
            state_d     = SEQ_RUN;
          end else if (rx_data == CMD_STEP) begin
            pc_write = 1'b1;
            drain_d  = '0;
            state_d  = SEQ_DRAIN;
          end
        end
      end
      SEQ_LOAD: begin
        if (asm_valid) begin
          imem_we = 1'b1;
          if (asm_word == HALT_WORD) begin
            state_d = SEQ_IDLE;
          end else if (addr_q == ADDR_MAX) begin
            load_err_d = 1'b1;
            state_d    = SEQ_IDLE;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      SEQ_RUN: begin
        // First RUN cycle sees the post-reset bubble, never a HALT.
        if (!run_first_q && (instr_in == HALT_WORD)) begin
          drain_d = '0;
          state_d = SEQ_DRAIN;
        end else begin
          pc_write = 1'b1;
        end
      end
      SEQ_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          tx_byte_d = wb_data[7:0];
          drain_d   = '0;
          state_d   = SEQ_SEND;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      SEQ_SEND: begin
        tx_start = 1'b1;
        state_d  = SEQ_WAIT_TX;
      end
      SEQ_WAIT_TX: begin
        if (tx_done) state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEQ_IDLE;
      addr_q      <= '0;
      drain_q     <= '0;
      tx_byte_q   <= '0;
      load_err_q  <= 1'b0;
      run_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      drain_q     <= drain_d;
      tx_byte_q   <= tx_byte_d;
      load_err_q  <= load_err_d;
      run_first_q <= run_first_d;
    end
  end

  assign imem_waddr = addr_q;
  assign imem_wdata = asm_word;
  assign tx_byte    = tx_byte_q;
  assign load_err   = load_err_q;
  assign busy       = (state_q != SEQ_IDLE);

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomized scoreboard bench for exec_sequencer with a small
// pipelined datapath model and an architectural reference interpreter.
module tb_exec_sequencer;

  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;
  localparam logic [7:0]  C_L    = 8'h4C;
  localparam logic [7:0]  C_R    = 8'h52;
  localparam logic [7:0]  C_S    = 8'h53;
  localparam int          DRAINC = 3;

  typedef struct { logic [5:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [7:0] b; int lat; } tx_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_done;
  logic [31:0] instr_in;
  logic [7:0]  wb_data;
  logic        dp_reset, pc_write, imem_we, tx_start, busy, load_err;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [7:0]  tx_byte;

  exec_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_done    (tx_done),
    .instr_in   (instr_in),
    .wb_data    (wb_data),
    .dp_reset   (dp_reset),
    .pc_write   (pc_write),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .tx_start   (tx_start),
    .tx_byte    (tx_byte),
    .busy       (busy),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  wr_t wr_q[$];
  tx_t tx_q[$];
  int  pcw_cnt = 0, dpr_cnt = 0, tx_cnt = 0;
  logic hold_tx = 1'b0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // ---------------- pipelined datapath model ----------------
  logic [31:0] imem [64];
  logic [5:0]  pc;
  logic [31:0] if_id, id_ex;
  logic        if_v, id_v;
  logic [7:0]  xr [32];
  logic [7:0]  wb;

  function automatic logic is_addi(logic [31:0] w);
    return (w[6:0] == 7'h13) && (w[14:12] == 3'b000) && (w != HALT);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) imem[i] <= 32'h0;
    end else if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
    if (reset || dp_reset) begin
      pc    <= '0;
      if_id <= '0;
      id_ex <= '0;
      if_v  <= 1'b0;
      id_v  <= 1'b0;
      wb    <= '0;
      for (int i = 0; i < 32; i++) xr[i] <= '0;
    end else begin
      if (pc_write) begin
        if_id <= imem[pc];
        pc    <= pc + 6'd1;
      end
      if_v  <= pc_write;
      id_ex <= if_id;
      id_v  <= if_v;
      if (id_v && is_addi(id_ex)) begin
        wb <= xr[id_ex[19:15]] + id_ex[27:20];
        if (id_ex[11:7] != 5'd0)
          xr[id_ex[11:7]] <= xr[id_ex[19:15]] + id_ex[27:20];
      end
    end
  end

  assign instr_in = if_id;
  assign wb_data  = wb;

  // ---------------- architectural reference ----------------
  function automatic logic [31:0] mk_addi(int rd, int rs1, int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
  endfunction

  // Value written by the n-th instruction executed in program order.
  function automatic logic [7:0] arch_run(logic [31:0] p[$], int n);
    logic [7:0] r [32];
    logic [7:0] last;
    logic [7:0] v;
    last = 8'h0;
    for (int i = 0; i < 32; i++) r[i] = 8'h0;
    for (int k = 0; k < n; k++) begin
      if (is_addi(p[k])) begin
        v = r[p[k][19:15]] + p[k][27:20];
        if (p[k][11:7] != 5'd0) r[p[k][11:7]] = v;
        last = v;
      end
    end
    return last;
  endfunction

  // ---------------- TX responder ----------------
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        int d;
        d = $urandom_range(1, 4);
        repeat (d) @(posedge clk);
        while (hold_tx) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  int   mcyc = 0;
  int   last_pcw = 0;
  logic in_wait = 1'b0;
  logic [7:0] held;

  always @(negedge clk) begin
    mcyc++;
    if (reset) begin
      in_wait = 1'b0;
    end else begin
      if (pc_write) begin
        pcw_cnt++;
        last_pcw = mcyc;
      end
      if (dp_reset) dpr_cnt++;
      if (imem_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected imem_we", 1, 0);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          check("imem_waddr", 32'(imem_waddr), 32'(e.a));
          check("imem_wdata", imem_wdata, e.d);
        end
      end
      if (tx_start) begin
        tx_cnt++;
        if (tx_q.size() == 0) begin
          check("unexpected tx_start", 1, 0);
        end else begin
          tx_t t;
          t = tx_q.pop_front();
          check("tx_byte", 32'(tx_byte), 32'(t.b));
          check("tx latency", 32'(mcyc - last_pcw), 32'(t.lat));
        end
        in_wait = 1'b1;
        held    = tx_byte;
      end else if (in_wait && tx_done) begin
        check("tx_byte held", 32'(tx_byte), 32'(held));
        in_wait = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(logic [7:0] b, int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = $urandom_range(0, 255);
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load_words(logic [31:0] w[$]);
    send_byte(C_L, $urandom_range(0, 2));
    foreach (w[i]) begin
      wr_t e;
      e.a = 6'(i);
      e.d = w[i];
      wr_q.push_back(e);
      for (int b = 0; b < 4; b++)
        send_byte(w[i][8*b +: 8], $urandom_range(0, 2));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_idle(string nm, int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(nm, 32'(busy), 0);
  endtask

  task automatic push_tx(logic [7:0] b, int lat);
    tx_t t;
    t.b = b;
    t.lat = lat;
    tx_q.push_back(t);
  endtask

  logic [31:0] prog[$];
  logic [31:0] words[$];
  int p0, d0, t0, n;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 0);
    check("rst pc_write", 32'(pc_write), 0);
    check("rst dp_reset", 32'(dp_reset), 0);
    check("rst imem_we", 32'(imem_we), 0);
    check("rst tx_start", 32'(tx_start), 0);
    check("rst tx_byte", 32'(tx_byte), 0);
    check("rst load_err", 32'(load_err), 0);
    check("rst waddr", 32'(imem_waddr), 0);
    reset = 1'b0;

    // 1: reset mid-LOAD, then a clean two-word load
    send_byte(C_L, 1);
    send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 1);
    do_reset();
    words = {32'h0102_0304, HALT};
    load_words(words);
    wait_idle("t1 idle", 20);
    check("t1 load_err", 32'(load_err), 0);

    // 2: overflow after 64 non-HALT words, then 'L' clears load_err
    words = {};
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = 32'h1234_5678;
      words.push_back(w);
    end
    load_words(words);
    wait_idle("t2 idle", 20);
    check("t2 load_err set", 32'(load_err), 1);
    check("t2 writes drained", 32'(wr_q.size()), 0);
    send_byte(C_L, 0);
    check("t2 load_err clr", 32'(load_err), 0);
    words = {HALT};
    begin
      wr_t e;
      e.a = 6'd0;
      e.d = HALT;
      wr_q.push_back(e);
    end
    for (int b = 0; b < 4; b++) send_byte(8'hFF, 0);
    wait_idle("t2b idle", 20);

    // 3: RUN on ADDI x1,x0,5 ; ADDI x1,x1,7 ; HALT
    do_reset();
    prog = {mk_addi(1, 0, 5), mk_addi(1, 1, 7), HALT};
    load_words(prog);
    wait_idle("t3 load idle", 20);
    p0 = pcw_cnt; d0 = dpr_cnt; t0 = tx_cnt;
    push_tx(arch_run(prog, 2), DRAINC + 2);
    send_byte(C_R, 0);
    wait_idle("t3 run idle", 200);
    check("t3 dp_reset cycles", 32'(dpr_cnt - d0), 1);
    check("t3 pc_write cycles", 32'(pcw_cnt - p0), 3);
    check("t3 tx count", 32'(tx_cnt - t0), 1);

    // 4: two STEPs on the same program
    do_reset();
    load_words(prog);
    wait_idle("t4 load idle", 20);
    for (int k = 1; k <= 2; k++) begin
      p0 = pcw_cnt; d0 = dpr_cnt; t0 = tx_cnt;
      push_tx(arch_run(prog, k), DRAINC + 1);
      send_byte(C_S, 0);
      wait_idle("t4 step idle", 100);
      check("t4 pc_write cycles", 32'(pcw_cnt - p0), 1);
      check("t4 no dp_reset", 32'(dpr_cnt - d0), 0);
      check("t4 tx count", 32'(tx_cnt - t0), 1);
    end

    // 5: 'L' during RUN and during WAIT_TX is ignored
    do_reset();
    prog = {};
    n = $urandom_range(6, 10);
    for (int i = 0; i < n; i++)
      prog.push_back(mk_addi($urandom_range(1, 3), $urandom_range(0, 3),
                             $urandom_range(0, 2047)));
    prog.push_back(HALT);
    load_words(prog);
    wait_idle("t5 load idle", 20);
    p0 = pcw_cnt; t0 = tx_cnt;
    hold_tx = 1'b1;
    push_tx(arch_run(prog, n), DRAINC + 2);
    send_byte(C_R, $urandom_range(0, 2));
    repeat (2) begin
      @(posedge clk); #1;
    end
    send_byte(C_L, 0);
    begin
      int w;
      w = 0;
      while (tx_cnt == t0 && w < 100) begin
        @(posedge clk); #1;
        w++;
      end
    end
    check("t5 tx seen", 32'(tx_cnt - t0), 1);
    send_byte(C_L, 1);
    check("t5 wait_tx busy", 32'(busy), 1);
    hold_tx = 1'b0;
    wait_idle("t5 idle", 50);
    check("t5 pc_write cycles", 32'(pcw_cnt - p0), 32'(n + 1));
    check("t5 load_err", 32'(load_err), 0);

    // 6: unknown byte in IDLE, then tx_done withheld in WAIT_TX
    do_reset();
    prog = {mk_addi($urandom_range(1, 31), 0, $urandom_range(1, 255)), HALT};
    load_words(prog);
    wait_idle("t6 load idle", 20);
    p0 = pcw_cnt; d0 = dpr_cnt; t0 = tx_cnt;
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    @(negedge clk);
    check("t6 quiet pc_write", 32'(pc_write), 0);
    check("t6 quiet dp_reset", 32'(dp_reset), 0);
    check("t6 quiet imem_we", 32'(imem_we), 0);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("t6 busy", 32'(busy), 0);
    check("t6 tx_byte", 32'(tx_byte), 0);
    check("t6 counts", 32'(pcw_cnt - p0 + dpr_cnt - d0 + tx_cnt - t0), 0);
    hold_tx = 1'b1;
    push_tx(arch_run(prog, 1), DRAINC + 1);
    send_byte(C_S, 0);
    repeat (DRAINC + 100) begin
      @(posedge clk); #1;
    end
    check("t6 still busy", 32'(busy), 1);
    check("t6 single tx_start", 32'(tx_cnt - t0), 1);
    hold_tx = 1'b0;
    wait_idle("t6 idle", 20);

    repeat (3) @(posedge clk);
    check("wr_q empty", 32'(wr_q.size()), 0);
    check("tx_q empty", 32'(tx_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
